// File: rtl/rrat_pkg.sv
// Shared machine sizes (also used by rat, rob and prf) plus the committed-state types and reset helpers.
package rrat_pkg;
  localparam int N                  = 4;
  localparam int RAT_SIZE           = 32;
  localparam int PRF_NUM_ENTRIES    = 64;
  localparam int REG_INDEX_BITS     = 5;
  localparam int PRF_NUM_INDEX_BITS = 6;

  typedef logic [REG_INDEX_BITS-1:0]     arch_t;
  typedef logic [PRF_NUM_INDEX_BITS-1:0] phys_t;
  typedef phys_t [RAT_SIZE-1:0]          map_t;
  typedef logic [PRF_NUM_ENTRIES-1:0]    prf_vec_t;

  // Identity map: arch reg i lives in phys reg i, so the low RAT_SIZE phys regs start owned.
  localparam prf_vec_t RESET_FREE = {{(PRF_NUM_ENTRIES-RAT_SIZE){1'b1}}, {RAT_SIZE{1'b0}}};

  function automatic map_t reset_map();
    map_t m;
    for (int i = 0; i < RAT_SIZE; i++) m[i] = phys_t'(i);
    return m;
  endfunction
endpackage

// File: rtl/rrat_retire_chain.sv
// Unrolled N-lane retire: applies lanes 0..N-1 in order to the committed map and free list.
module rrat_retire_chain
  import rrat_pkg::*;
(
  input  logic [N-1:0] i_valid,
  input  arch_t [N-1:0] i_arch,
  input  phys_t [N-1:0] i_phys,
  input  map_t          i_map,
  input  prf_vec_t      i_free,
  output map_t          o_map,
  output prf_vec_t      o_free,
  output prf_vec_t      o_freed,
  output logic          o_bad
);
  map_t     w_map;
  prf_vec_t w_free;
  prf_vec_t w_freed;
  phys_t    w_old;
  logic     w_bad;

  // Each lane sees the running map, so a repeated arch reg frees the earlier lane's phys.
  always_comb begin
    w_map   = i_map;
    w_free  = i_free;
    w_freed = '0;
    w_old   = '0;
    w_bad   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_valid[i]) begin
        w_old            = w_map[i_arch[i]];
        w_freed[w_old]   = 1'b1;
        w_free[w_old]    = 1'b1;
        w_bad            = w_bad | ~w_free[i_phys[i]];
        w_free[i_phys[i]] = 1'b0;
        w_map[i_arch[i]] = i_phys[i];
      end
    end
  end

  assign o_map   = w_map;
  assign o_free  = w_free;
  assign o_freed = w_freed;
  assign o_bad   = w_bad;
endmodule

// File: rtl/rrat.sv
// Retirement RAT: committed arch->phys map, committed free list, and per-cycle freed-phys pulse.
module rrat
  import rrat_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  retire_valid,
  input  arch_t [N-1:0] retire_arch_reg,
  input  phys_t [N-1:0] retire_phys_reg,
  output map_t          rrat_entries,
  output prf_vec_t      rrat_free_list,
  output prf_vec_t      free_vector_from_rrat
);
  map_t     r_map;
  prf_vec_t r_free;
  prf_vec_t r_freed;
  map_t     w_map;
  prf_vec_t w_free;
  prf_vec_t w_freed;
  logic     w_bad;

  rrat_retire_chain u_chain (
    .i_valid (retire_valid),
    .i_arch  (retire_arch_reg),
    .i_phys  (retire_phys_reg),
    .i_map   (r_map),
    .i_free  (r_free),
    .o_map   (w_map),
    .o_free  (w_free),
    .o_freed (w_freed),
    .o_bad   (w_bad)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_map   <= reset_map();
      r_free  <= RESET_FREE;
      r_freed <= '0;
    end else begin
      r_map   <= w_map;
      r_free  <= w_free;
      r_freed <= w_freed;
    end
  end

  // A retiring phys must not already be committed to some other arch reg.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_alloc_owned: assert (!w_bad);
      a_owned_count: assert ($countones(~r_free) == RAT_SIZE);
    end
  end

  assign rrat_entries          = r_map;
  assign rrat_free_list        = r_free;
  assign free_vector_from_rrat = r_freed;
endmodule

// File: tb/tb_rrat.sv
// Directed bench for rrat: hand-computed map / free list / freed-vector after each retire group.
module tb_rrat;
  import rrat_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  retire_valid;
  arch_t [N-1:0] retire_arch_reg;
  phys_t [N-1:0] retire_phys_reg;
  map_t          rrat_entries;
  prf_vec_t      rrat_free_list;
  prf_vec_t      free_vector_from_rrat;

  int tests = 0;
  int fails = 0;
  map_t     exp_map;
  prf_vec_t exp_free;
  prf_vec_t exp_fv;

  always #5 clock = ~clock;

  rrat dut (
    .clock                 (clock),
    .reset                 (reset),
    .retire_valid          (retire_valid),
    .retire_arch_reg       (retire_arch_reg),
    .retire_phys_reg       (retire_phys_reg),
    .rrat_entries          (rrat_entries),
    .rrat_free_list        (rrat_free_list),
    .free_vector_from_rrat (free_vector_from_rrat)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    retire_valid    = '0;
    retire_arch_reg = '0;
    retire_phys_reg = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_map"},  rrat_entries, reset_map());
    chk({tag, "_free"}, 192'(rrat_free_list), 192'(64'hFFFF_FFFF_0000_0000));
    chk({tag, "_fv"},   192'(free_vector_from_rrat), 192'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clock);
    step();
    reset = 1'b0;
    check_reset("t1_reset");

    // t2: lane0 arch3 -> phys40
    retire_valid = 4'b0001; retire_arch_reg[0] = 5'd3; retire_phys_reg[0] = 6'd40;
    step();
    idle();
    exp_map = reset_map(); exp_map[3] = 6'd40;
    exp_free = 64'hFFFF_FFFF_0000_0000; exp_free[40] = 1'b0; exp_free[3] = 1'b1;
    chk("t2_entry3", 192'(rrat_entries[3]), 192'd40);
    chk("t2_map", rrat_entries, exp_map);
    chk("t2_fv", 192'(free_vector_from_rrat), 192'(64'h8));
    chk("t2_free", 192'(rrat_free_list), 192'(exp_free));
    step();
    chk("t2_fv_idle", 192'(free_vector_from_rrat), 192'd0);

    // t3 (from fresh reset): all lanes arch5 -> 40,41,42,43
    reset = 1'b1; step(); reset = 1'b0;
    retire_valid = 4'b1111;
    retire_arch_reg = {5'd5, 5'd5, 5'd5, 5'd5};
    retire_phys_reg = {6'd43, 6'd42, 6'd41, 6'd40};
    step();
    idle();
    exp_map = reset_map(); exp_map[5] = 6'd43;
    exp_free = 64'hFFFF_FFFF_0000_0000; exp_free[5] = 1'b1; exp_free[43] = 1'b0;
    exp_fv = '0; exp_fv[5] = 1'b1; exp_fv[40] = 1'b1; exp_fv[41] = 1'b1; exp_fv[42] = 1'b1;
    chk("t3_map", rrat_entries, exp_map);
    chk("t3_fv", 192'(free_vector_from_rrat), 192'(exp_fv));
    chk("t3_free", 192'(rrat_free_list), 192'(exp_free));

    // t4: sparse valid 1010, garbage on lanes 0 and 2
    retire_valid = 4'b1010;
    retire_arch_reg = {5'd2, 5'd9, 5'd1, 5'd5};
    retire_phys_reg = {6'd51, 6'd60, 6'd50, 6'd43};
    step();
    idle();
    exp_map[1] = 6'd50; exp_map[2] = 6'd51;
    exp_free[1] = 1'b1; exp_free[2] = 1'b1; exp_free[50] = 1'b0; exp_free[51] = 1'b0;
    chk("t4_map", rrat_entries, exp_map);
    chk("t4_fv", 192'(free_vector_from_rrat), 192'(64'h6));
    chk("t4_free", 192'(rrat_free_list), 192'(exp_free));

    // t5: back-to-back arch7 -> 45 then 46
    retire_valid = 4'b0001; retire_arch_reg[0] = 5'd7; retire_phys_reg[0] = 6'd45;
    step();
    chk("t5_fv_a", 192'(free_vector_from_rrat), 192'(64'h80));
    retire_valid = 4'b0001; retire_arch_reg[0] = 5'd7; retire_phys_reg[0] = 6'd46;
    step();
    idle();
    exp_map[7] = 6'd46;
    exp_free[7] = 1'b1; exp_free[45] = 1'b1; exp_free[46] = 1'b0;
    exp_fv = '0; exp_fv[45] = 1'b1;
    chk("t5_map", rrat_entries, exp_map);
    chk("t5_fv_b", 192'(free_vector_from_rrat), 192'(exp_fv));
    chk("t5_free", 192'(rrat_free_list), 192'(exp_free));
    step();
    chk("t5_fv_idle", 192'(free_vector_from_rrat), 192'd0);

    // t6: reset beats a full valid group in the same cycle
    reset = 1'b1;
    retire_valid = 4'b1111;
    retire_arch_reg = {5'd13, 5'd12, 5'd11, 5'd10};
    retire_phys_reg = {6'd55, 6'd54, 6'd53, 6'd52};
    step();
    reset = 1'b0;
    idle();
    check_reset("t6_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
